fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
Output reorder buffer placed after the last radix-2 SDF butterfly stage of the FFT pipeline.
- The pipeline emits bins in bit-reversed order. This block accepts one complex sample per valid cycle and re-emits each N-sample frame in natural order (bin 0..N-1) as a contiguous burst.
- Ping-pong double buffering: a frame is written to one bank while the previous frame is read from the other.
- Sustains continuous 1 sample/cycle streaming with no backpressure.

Parameters:
- WIDTH, 13, bit width of each signed real/imag sample (matches the final stage output width)
- N, 64, frame length (FFT size); must be a power of 2 and at least 4; LOG2N = $clog2(N)

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  synchronous, active-high reset
- In_valid  input  1  In_re/In_im hold a valid sample this cycle
- In_re  input  WIDTH  signed real part, bit-reversed bin order
- In_im  input  WIDTH  signed imag part, bit-reversed bin order
- Out_valid  output  1  Out_re/Out_im/Out_idx valid this cycle
- Out_re  output  WIDTH  signed real part, natural order (registered)
- Out_im  output  WIDTH  signed imag part, natural order (registered)
- Out_idx  output  LOG2N  natural bin index of the current output (registered)

Behaviour:
- One clock (Clk). Reset is synchronous and active-high; it is sampled only on the rising edge of Clk.
- Storage: two banks, bank[b][0..N-1], each entry {re, im} of WIDTH bits. Memory contents are not reset.
- Write side:
  - State: w_cnt (LOG2N bits) and w_bank (1 bit).
  - On a cycle with In_valid=1, write bank[w_bank][bitrev(w_cnt)] and increment w_cnt.
  - When w_cnt==N-1 is written: w_cnt wraps to 0, w_bank toggles, and full[old w_bank] is set.
  - In_valid=0 holds w_cnt and w_bank. Gaps may occur anywhere inside a frame.
- Read side FSM, two states:
  - IDLE: Out_valid=0. If any full[b] is set, load r_bank=b, set r_cnt=0, go to READ.
  - READ: each cycle, register Out_re/Out_im <= bank[r_bank][r_cnt], Out_idx <= r_cnt, Out_valid <= 1; increment r_cnt.
  - After the r_cnt==N-1 read, clear full[r_bank]. If the other bank's full flag is set in that same cycle, go directly to READ on it with no bubble; otherwise go to IDLE.
- Latency: if the last sample of a frame is written in cycle t, then Out_valid=1 with Out_idx=0 in cycle t+2, and Out_idx=N-1 in cycle t+N+1.
- Output bursts are always exactly N contiguous cycles with Out_idx counting 0..N-1.
- Simultaneous write and read on different banks is normal operation.
- A bank's full flag cannot be set while that bank is being read. The read drains in N cycles, and the write of the next frame takes at least N cycles.
- Partial frame: no output until all N samples have been written.
- Reset, including mid-frame or mid-burst:
  - w_cnt=0, w_bank=0, r_cnt=0, r_bank=0, full[1:0]=0, FSM=IDLE.
  - Out_valid=0, Out_re=0, Out_im=0, Out_idx=0.
  - Any partially written or partially read frame is discarded. The next sample with In_valid=1 after reset is bin position 0 of a new frame.
- Outputs hold their last values while Out_valid=0.
- Widths: data passes through unmodified; no growth, no rounding.

Optional Feature:
- Macro: FFT_REORDER_CONJ_EN
- Defined: Out_im = -(stored im), giving the complex conjugate for IFFT-via-conjugation reuse of the forward pipeline.
  - Negation saturates: -(-2^(WIDTH-1)) yields 2^(WIDTH-1)-1.
  - Out_re is unchanged. Latency is unchanged.
- Undefined: Out_im = stored im exactly. No negation logic is synthesized.

Test Plan:
1. Basic reorder: N=8, WIDTH=13, Reset for 2 cycles, then 8 consecutive valid inputs In_re = 0,40,20,60,10,50,30,70 and In_im = -In_re.
   - Required: starting 2 cycles after the last input, Out_re = 0,10,20,...,70, Out_im = 0,-10,...,-70, Out_idx = 0..7, Out_valid high for exactly 8 cycles.
2. Back-to-back streaming: 4 frames of N=8 with In_valid held at 1 for 32 cycles.
   - Required: Out_valid high for 32 contiguous cycles with no bubble; each frame is correctly reordered; banks alternate.
3. Input gaps: the frame from scenario 1, with In_valid=0 inserted after samples 2 and 5 (3 idle cycles each).
   - Required: identical output sequence, starting 2 cycles after the 8th valid sample.
4. Reset mid-operation: assert Reset during output cycle Out_idx=3, then send a fresh frame.
   - Required: Out_valid=0 and all outputs 0 in the cycle after Reset. The new frame is output correctly, with no residue from the old frame.
5. Partial frame: send 5 samples, then hold In_valid=0 for 20 cycles.
   - Required: Out_valid stays 0. Sending 3 more samples completes the frame and produces a correct burst.
6. With FFT_REORDER_CONJ_EN defined: input In_im = -4096 at position 0 and 100 at position 4.
   - Required: Out_im at Out_idx=0 is 4095; Out_im at Out_idx=1 is -100.

Source files
------------

// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle for the FFT bit-reverse reorder buffer.
// The slave view is the reorder block; the master view is the upstream source and downstream sink.
interface fft_bitrev_reorder_if #(
  parameter int WIDTH = 13,
  parameter int N     = 64
);
  localparam int LOG2N = $clog2(N);

  logic                    In_valid;
  logic signed [WIDTH-1:0] In_re;
  logic signed [WIDTH-1:0] In_im;
  logic                    Out_valid;
  logic signed [WIDTH-1:0] Out_re;
  logic signed [WIDTH-1:0] Out_im;
  logic [LOG2N-1:0]        Out_idx;

  modport master (
    output In_valid, In_re, In_im,
    input  Out_valid, Out_re, Out_im, Out_idx
  );

  modport slave (
    input  In_valid, In_re, In_im,
    output Out_valid, Out_re, Out_im, Out_idx
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: takes bit-reversed FFT bins, re-emits each frame in natural order.
// Define FFT_REORDER_CONJ_EN to output the complex conjugate (saturating negation of imag).
module fft_bitrev_reorder #(
  parameter int WIDTH = 13,
  parameter int N     = 64
) (
  input logic                  Clk,
  input logic                  Reset,
  fft_bitrev_reorder_if.slave  bus
);
  localparam int LOG2N = $clog2(N);
  localparam int DW    = 2 * WIDTH;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_t;

  // ---------------- write side ----------------
  logic [LOG2N-1:0] w_cnt_reg;
  logic             w_bank_reg;
  logic [LOG2N-1:0] w_addr_rev;
  logic             frame_done;
  logic [WIDTH-1:0] im_wr;

  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
      assign w_addr_rev[gi] = w_cnt_reg[LOG2N-1-gi];
    end
  endgenerate

  assign frame_done = bus.In_valid && (w_cnt_reg == LAST_IDX);

`ifdef FFT_REORDER_CONJ_EN
  localparam logic [WIDTH-1:0] IM_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] IM_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  // Conjugate before storage so the read path stays a plain registered RAM read.
  assign im_wr = (bus.In_im == IM_MIN) ? IM_MAX : -bus.In_im;
`else
  assign im_wr = bus.In_im;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      w_cnt_reg  <= '0;
      w_bank_reg <= 1'b0;
    end else if (bus.In_valid) begin
      w_cnt_reg <= w_cnt_reg + 1'b1;
      if (frame_done)
        w_bank_reg <= ~w_bank_reg;
    end
  end

  // ---------------- storage ----------------
  logic [DW-1:0] mem [0:2*N-1];

  always_ff @(posedge Clk) begin
    if (bus.In_valid)
      mem[{w_bank_reg, w_addr_rev}] <= {bus.In_re, im_wr};
  end

  // ---------------- read side ----------------
  state_t           state_reg;
  logic [LOG2N-1:0] r_cnt_reg;
  logic             r_bank_reg;
  logic [1:0]       full_reg;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;
  logic             out_valid_reg;
  logic [LOG2N-1:0] out_idx_reg;
  logic [DW-1:0]    rd_data_reg;
  logic             rd_en;

  assign rd_en = (state_reg == S_READ);

  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (frame_done)
      full_set[w_bank_reg] = 1'b1;
    if (rd_en && (r_cnt_reg == LAST_IDX))
      full_clr[r_bank_reg] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= S_IDLE;
      r_cnt_reg     <= '0;
      r_bank_reg    <= 1'b0;
      full_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
    end else begin
      full_reg <= (full_reg & ~full_clr) | full_set;
      case (state_reg)
        S_IDLE: begin
          out_valid_reg <= 1'b0;
          if (full_reg != 2'b00) begin
            // Only one bank can be pending here; bank 0 wins a tie.
            r_bank_reg <= ~full_reg[0];
            r_cnt_reg  <= '0;
            state_reg  <= S_READ;
          end
        end
        S_READ: begin
          out_valid_reg <= 1'b1;
          out_idx_reg   <= r_cnt_reg;
          r_cnt_reg     <= r_cnt_reg + 1'b1;
          if (r_cnt_reg == LAST_IDX) begin
            // Chain straight into the other bank when it is already full.
            if (full_reg[~r_bank_reg])
              r_bank_reg <= ~r_bank_reg;
            else
              state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      rd_data_reg <= '0;
    else if (rd_en)
      rd_data_reg <= mem[{r_bank_reg, r_cnt_reg}];
  end

  assign bus.Out_valid = out_valid_reg;
  assign bus.Out_idx   = out_idx_reg;
  assign bus.Out_re    = rd_data_reg[DW-1:WIDTH];
  assign bus.Out_im    = rd_data_reg[WIDTH-1:0];
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder at N=8: reorder, streaming, gaps, reset, partial frame, conjugate.
// Build with FFT_REORDER_CONJ_EN defined to check the conjugating variant.
module tb_fft_bitrev_reorder;
  localparam int WIDTH = 13;
  localparam int N     = 8;

  logic Clk;
  logic Reset;
  int   n_assert;
  int   n_fail;
  int   br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_bitrev_reorder_if #(.WIDTH(WIDTH), .N(N)) bus ();

  fft_bitrev_reorder #(.WIDTH(WIDTH), .N(N)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int exp_im(input int v);
`ifdef FFT_REORDER_CONJ_EN
    if (v == -4096) return 4095;
    return -v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input int re, input int im);
    bus.In_valid = v;
    bus.In_re    = WIDTH'(re);
    bus.In_im    = WIDTH'(im);
    @(posedge Clk);
    #1;
    bus.In_valid = 1'b0;
  endtask

  // Sample at frame position p of a frame whose natural bin k holds re=rb+10k, im=ib-10k.
  task automatic samp(input int rb, input int ib, input int p);
    step(1'b1, rb + 10 * br_tab[p], ib - 10 * br_tab[p]);
  endtask

  task automatic expect_burst(input string tag, input int rb, input int ib);
    step(1'b0, 0, 0);
    chk({tag, " pre valid"}, bus.Out_valid, 0);
    for (int k = 0; k < N; k++) begin
      step(1'b0, 0, 0);
      chk($sformatf("%s valid[%0d]", tag, k), bus.Out_valid, 1);
      chk($sformatf("%s idx[%0d]", tag, k), bus.Out_idx, k);
      chk($sformatf("%s re[%0d]", tag, k), bus.Out_re, rb + 10 * k);
      chk($sformatf("%s im[%0d]", tag, k), bus.Out_im, exp_im(ib - 10 * k));
    end
    step(1'b0, 0, 0);
    chk({tag, " post valid"}, bus.Out_valid, 0);
    chk({tag, " hold idx"}, bus.Out_idx, N - 1);
    chk({tag, " hold re"}, bus.Out_re, rb + 70);
    $display("tb: %s burst checked", tag);
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    Reset        = 1'b1;
    bus.In_valid = 1'b0;
    bus.In_re    = '0;
    bus.In_im    = '0;

    // Reset state
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    Reset = 1'b0;
    chk("rst valid", bus.Out_valid, 0);
    chk("rst idx", bus.Out_idx, 0);
    chk("rst re", bus.Out_re, 0);
    chk("rst im", bus.Out_im, 0);
    $display("tb: reset state checked");

    // 1: basic reorder, In_im = -In_re
    for (int p = 0; p < N; p++) samp(0, 0, p);
    expect_burst("s1", 0, 0);

    // 2: four frames back to back; outputs contiguous from edge 9 to edge 40
    for (int e = 0; e < 43; e++) begin
      if (e < 32) samp(100 * (e / 8), 3 * (e / 8), e % 8);
      else        step(1'b0, 0, 0);
      if (e >= 9 && e <= 40) begin
        chk($sformatf("s2 valid[%0d]", e), bus.Out_valid, 1);
        chk($sformatf("s2 idx[%0d]", e), bus.Out_idx, (e - 9) % 8);
        chk($sformatf("s2 re[%0d]", e), bus.Out_re, 100 * ((e - 9) / 8) + 10 * ((e - 9) % 8));
        chk($sformatf("s2 im[%0d]", e), bus.Out_im, exp_im(3 * ((e - 9) / 8) - 10 * ((e - 9) % 8)));
      end else begin
        chk($sformatf("s2 valid[%0d]", e), bus.Out_valid, 0);
      end
    end
    $display("tb: s2 streaming checked");

    // 3: same frame as 1 with two 3-cycle gaps
    for (int p = 0; p < 3; p++) samp(0, 0, p);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0);
    for (int p = 3; p < 6; p++) samp(0, 0, p);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0);
    for (int p = 6; p < 8; p++) samp(0, 0, p);
    expect_burst("s3", 0, 0);

    // 4: reset while Out_idx=3, with a partial next frame in flight
    for (int p = 0; p < N; p++) samp(500, 20, p);
    step(1'b0, 0, 0);
    chk("s4 pre valid", bus.Out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) samp(900, 0, k);
      else       step(1'b0, 0, 0);
      chk($sformatf("s4 idx[%0d]", k), bus.Out_idx, k);
      chk($sformatf("s4 re[%0d]", k), bus.Out_re, 500 + 10 * k);
    end
    Reset = 1'b1;
    step(1'b0, 0, 0);
    Reset = 1'b0;
    chk("s4 rst valid", bus.Out_valid, 0);
    chk("s4 rst idx", bus.Out_idx, 0);
    chk("s4 rst re", bus.Out_re, 0);
    chk("s4 rst im", bus.Out_im, 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 0, 0);
      chk($sformatf("s4 quiet[%0d]", i), bus.Out_valid, 0);
    end
    for (int p = 0; p < N; p++) samp(300, -5, p);
    expect_burst("s4", 300, -5);

    // 5: partial frame stalls, then completes
    for (int p = 0; p < 5; p++) samp(600, 7, p);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 0, 0);
      chk($sformatf("s5 stall[%0d]", i), bus.Out_valid, 0);
    end
    for (int p = 5; p < 8; p++) samp(600, 7, p);
    expect_burst("s5", 600, 7);

    // 6: imag extremes at positions 0 and 4 (bins 0 and 1)
    for (int p = 0; p < N; p++) begin
      if (p == 0)      step(1'b1, 0, -4096);
      else if (p == 4) step(1'b1, 10, 100);
      else             step(1'b1, 10 * br_tab[p], -10 * br_tab[p]);
    end
    step(1'b0, 0, 0);
    for (int k = 0; k < N; k++) begin
      step(1'b0, 0, 0);
      chk($sformatf("s6 idx[%0d]", k), bus.Out_idx, k);
      chk($sformatf("s6 re[%0d]", k), bus.Out_re, 10 * k);
      if (k == 0)      chk("s6 im[0]", bus.Out_im, exp_im(-4096));
      else if (k == 1) chk("s6 im[1]", bus.Out_im, exp_im(100));
      else             chk($sformatf("s6 im[%0d]", k), bus.Out_im, exp_im(-10 * k));
    end
    $display("tb: s6 imag extremes checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
